simon_game_ctrl: RTL and testbench

//  Game sequencer for Simon Says: grows a random symbol sequence and plays it on the LEDs.

---
 rtl/simon_pkg.sv | 29 ++
 rtl/simon_lfsr.sv | 36 +++
 rtl/simon_game_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_simon_game_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says game sequencer.
// Latency: none, because the package holds only types, constants and a combinational helper.
// Backpressure: not applicable.
package simon_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_GAP,
    WAIT_IN,
    CHECK,
    FAIL,
    WIN
  } state_t;

  // One sequence symbol: a 2-bit code selecting one of four LEDs/switches
  typedef logic [1:0] sym_t;

  // Feedback taps for the 8-bit shift-left LFSR: bits 7, 5, 4 and 3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Converts a symbol code into its one-hot LED pattern
  function automatic logic [3:0] sym2led(input sym_t s);
    sym2led = 4'b0001 << s;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR (shift left), used as the symbol source; a zero seed is replaced by 8'h01.
// Latency: the new value appears one cycle after step or load; sym is lfsr[1:0] taken combinationally.
// Backpressure: none; the LFSR holds its value whenever step and load are both low.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic load,
  output sym_t sym
);

  // All-zero is the lock-up state of an XOR LFSR, so it is never used as a seed
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr;
  logic       fb;

  assign fb  = ^(lfsr & LFSR_TAPS);
  assign sym = lfsr[1:0];

  // Shift register: reload from the seed, or advance by one step when enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED_EFF;
    end else if (load) begin
      lfsr <= SEED_EFF;
    end else if (step) begin
      lfsr <= {lfsr[6:0], fb};
    end
  end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says sequencer: grows a random sequence, plays it on the LEDs, then checks the player's entries.
// Latency: each entry is checked two cycles after its input_done rising edge (capture, then CHECK).
// Backpressure: none; input_done edges outside WAIT_IN and start pulses while busy are dropped.
// Optional feature: define SIMON_SPEEDUP_EN to halve the symbol show time every 4 levels.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         SHOW_CYCLES = 25_000_000,
  parameter int         GAP_CYCLES  = 12_500_000,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_off,
  input  logic       start,
  input  logic       input_done,
  input  logic [3:0] to_cmp,
  output logic [3:0] led_show,
  output logic       show_active,
  output logic [5:0] level,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  localparam int TMAX  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << IW;

  localparam logic [TW-1:0] SHOW_T   = TW'(SHOW_CYCLES);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [5:0]    MAX_L    = 6'(MAX_LEN);

  state_t        state, state_nxt;
  logic [5:0]    len, len_nxt;
  logic [5:0]    idx, idx_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    cmp_q, cmp_nxt;
  logic          done_prev;
  logic          seq_wr;
  logic          lfsr_step;
  sym_t          lfsr_sym;
  sym_t          seq [DEPTH];
  sym_t          cur_sym;
  logic [TW-1:0] show_time;
  logic          in_edge;
  logic          idx_last;
  logic          show_done;
  logic          gap_done;

  // Symbol source; it is never reloaded mid-game, so the seed only applies at reset
  simon_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .load  (1'b0),
    .sym   (lfsr_sym)
  );

  assign cur_sym  = seq[idx[IW-1:0]];
  assign in_edge  = input_done & ~done_prev;
  assign idx_last = (idx == (len - 6'd1));

  // Show time per symbol, which shrinks with level when the speed-up build option is enabled
  always_comb begin
`ifdef SIMON_SPEEDUP_EN
    show_time = SHOW_T >> len[5:2];
    if (show_time == '0) begin
      show_time = TW'(1);
    end
`else
    show_time = SHOW_T;
`endif
  end

  assign show_done = (timer == (show_time - TW'(1)));
  assign gap_done  = (timer == GAP_LAST);

  // Next-state and datapath updates; on_off low overrides everything except the LFSR step rule
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    idx_nxt   = idx;
    timer_nxt = timer;
    cmp_nxt   = cmp_q;
    seq_wr    = 1'b0;
    lfsr_step = (state == IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = GEN;
          len_nxt   = 6'd0;
        end
      end

      GEN: begin
        seq_wr    = 1'b1;
        lfsr_step = 1'b1;
        len_nxt   = len + 6'd1;
        idx_nxt   = 6'd0;
        timer_nxt = '0;
        state_nxt = SHOW_ON;
      end

      SHOW_ON: begin
        if (show_done) begin
          timer_nxt = '0;
          state_nxt = SHOW_GAP;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      SHOW_GAP: begin
        if (gap_done) begin
          timer_nxt = '0;
          if (idx_last) begin
            idx_nxt   = 6'd0;
            state_nxt = WAIT_IN;
          end else begin
            idx_nxt   = idx + 6'd1;
            state_nxt = SHOW_ON;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      WAIT_IN: begin
        if (in_edge) begin
          cmp_nxt   = to_cmp;
          state_nxt = CHECK;
        end
      end

      CHECK: begin
        // A non-one-hot or zero entry never equals a one-hot LED pattern, so it fails here too
        if (cmp_q != sym2led(cur_sym)) begin
          state_nxt = FAIL;
        end else if (idx_last) begin
          state_nxt = (len == MAX_L) ? WIN : GEN;
        end else begin
          idx_nxt   = idx + 6'd1;
          state_nxt = WAIT_IN;
        end
      end

      FAIL, WIN: begin
        if (start) begin
          state_nxt = GEN;
          len_nxt   = 6'd0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!on_off) begin
      state_nxt = IDLE;
      len_nxt   = 6'd0;
      idx_nxt   = 6'd0;
      timer_nxt = '0;
      seq_wr    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: length, index, timer, captured entry, edge history and sequence memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len       <= 6'd0;
      idx       <= 6'd0;
      timer     <= '0;
      cmp_q     <= 4'd0;
      done_prev <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        seq[i] <= '0;
      end
    end else begin
      len       <= len_nxt;
      idx       <= idx_nxt;
      timer     <= timer_nxt;
      cmp_q     <= cmp_nxt;
      done_prev <= input_done;
      if (seq_wr) begin
        seq[len[IW-1:0]] <= lfsr_sym;
      end
    end
  end

  // Outputs are decoded from the registered state, so they change together with it
  always_comb begin
    led_show    = (state == SHOW_ON) ? sym2led(cur_sym) : 4'd0;
    show_active = (state == SHOW_ON) || (state == SHOW_GAP);
    level       = len;
    busy        = !((state == IDLE) || (state == FAIL) || (state == WIN));
    game_over   = (state == FAIL);
    win         = (state == WIN);
  end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl with short show/gap times and a small winning length.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_simon_game_ctrl;

`ifdef SIMON_SPEEDUP_EN
  localparam int MAXL    = 8;
  localparam bit SPEEDUP = 1'b1;
`else
  localparam int MAXL    = 3;
  localparam bit SPEEDUP = 1'b0;
`endif
  localparam int SHOWC = 4;
  localparam int GAPC  = 2;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       on_off     = 1'b0;
  logic       start      = 1'b0;
  logic       input_done = 1'b0;
  logic [3:0] to_cmp     = 4'd0;
  logic [3:0] led_show;
  logic       show_active;
  logic [5:0] level;
  logic       busy;
  logic       game_over;
  logic       win;
  logic [13:0] outs;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_lfsr;
  logic [1:0] exp_seq [32];
  int         exp_len;

  assign outs = {led_show, show_active, level, busy, game_over, win};

  always #5 clk = ~clk;

  simon_game_ctrl #(
    .MAX_LEN     (MAXL),
    .SHOW_CYCLES (SHOWC),
    .GAP_CYCLES  (GAPC),
    .LFSR_SEED   (8'h01)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .on_off      (on_off),
    .start       (start),
    .input_done  (input_done),
    .to_cmp      (to_cmp),
    .led_show    (led_show),
    .show_active (show_active),
    .level       (level),
    .busy        (busy),
    .game_over   (game_over),
    .win         (win)
  );

  function automatic logic [7:0] lfsr_nxt(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [3:0] led_of(input logic [1:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction

  function automatic int show_len(input int lvl);
    int s;
    s = SHOWC >> (SPEEDUP ? (lvl >> 2) : 0);
    return (s < 1) ? 1 : s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick;
    tick();
    exp_lfsr = lfsr_nxt(exp_lfsr);
  endtask

  // Pulses start for one cycle; the LFSR also steps on that edge only when leaving IDLE
  task automatic do_start(input bit from_idle);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (from_idle) exp_lfsr = lfsr_nxt(exp_lfsr);
    exp_len = 0;
  endtask

  // Advances out of GEN, recording the symbol the bench expects to be appended
  task automatic gen_tick;
    exp_seq[exp_len] = exp_lfsr[1:0];
    exp_lfsr = lfsr_nxt(exp_lfsr);
    exp_len++;
    tick();
  endtask

  // Walks the whole playback, counting cycles that deviate from the expected LED pattern
  task automatic playback(output int bad);
    int sl;
    bad = 0;
    sl  = show_len(exp_len);
    for (int i = 0; i < exp_len; i++) begin
      for (int c = 0; c < sl; c++) begin
        if (led_show !== led_of(exp_seq[i]) || show_active !== 1'b1 ||
            busy !== 1'b1 || level !== 6'(exp_len)) bad++;
        tick();
        start = 1'b0;
      end
      for (int c = 0; c < GAPC; c++) begin
        if (led_show !== 4'd0 || show_active !== 1'b1 || busy !== 1'b1) bad++;
        tick();
        start = 1'b0;
      end
    end
    if (show_active !== 1'b0 || busy !== 1'b1 || led_show !== 4'd0) bad++;
  endtask

  task automatic play_level(output int bad);
    gen_tick();
    playback(bad);
  endtask

  // Delivers one entry with a single-cycle input_done pulse and steps through CHECK
  task automatic enter(input logic [3:0] v);
    to_cmp     = v;
    input_done = 1'b1;
    tick();
    input_done = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    int         bad;
    logic [7:0] prev;
    reset  = 1'b0;
    on_off = 1'b1;
    repeat (3) tick();
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    checks++;
    if (dut.u_lfsr.lfsr !== 8'h01) begin
      errors++;
      $display("FAIL reset_lfsr got %h want 01", dut.u_lfsr.lfsr);
    end
    reset    = 1'b1;
    exp_lfsr = 8'h01;
    bad      = 0;
    for (int i = 0; i < 20; i++) begin
      prev = dut.u_lfsr.lfsr;
      idle_tick();
      if (dut.u_lfsr.lfsr === prev || dut.u_lfsr.lfsr !== exp_lfsr) bad++;
      if (outs !== 14'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_freerun bad_cycles %0d want 0", bad);
    end
    checks++;
    if (dut.u_lfsr.lfsr !== exp_lfsr) begin
      errors++;
      $display("FAIL idle_lfsr got %h want %h", dut.u_lfsr.lfsr, exp_lfsr);
    end
  endtask

  task automatic test_first_round;
    int bad;
    repeat (5) idle_tick();
    do_start(1'b1);
    checks++;
    if (busy !== 1'b1 || level !== 6'd0 || show_active !== 1'b0) begin
      errors++;
      $display("FAIL gen_cycle busy %b level %0d show %b want 1 0 0", busy, level, show_active);
    end
    gen_tick();
    checks++;
    if (led_show !== led_of(exp_seq[0]) || level !== 6'd1) begin
      errors++;
      $display("FAIL first_symbol led %b level %0d want %b 1", led_show, level, led_of(exp_seq[0]));
    end
    playback(bad);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL first_playback bad_cycles %0d want 0", bad);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || level !== 6'd1 || show_active !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL wait_in_hold busy %b level %0d show %b go %b want 1 1 0 0",
               busy, level, show_active, game_over);
    end
    enter(led_of(exp_seq[0]));
    checks++;
    if (busy !== 1'b1 || game_over !== 1'b0 || level !== 6'd1) begin
      errors++;
      $display("FAIL round1_pass busy %b go %b level %0d want 1 0 1", busy, game_over, level);
    end
  endtask

  task automatic test_win;
    int bad;
    for (int lvl = 2; lvl <= MAXL; lvl++) begin
      play_level(bad);
      checks++;
      if (bad !== 0 || level !== 6'(lvl)) begin
        errors++;
        $display("FAIL playback_level%0d bad_cycles %0d level %0d want 0 %0d", lvl, bad, level, lvl);
      end
      for (int j = 0; j < exp_len; j++) enter(led_of(exp_seq[j]));
    end
    checks++;
    if (win !== 1'b1 || busy !== 1'b0 || game_over !== 1'b0 || level !== 6'(MAXL)) begin
      errors++;
      $display("FAIL win_state win %b busy %b go %b level %0d want 1 0 0 %0d",
               win, busy, game_over, level, MAXL);
    end
    repeat (3) tick();
    checks++;
    if (win !== 1'b1 || level !== 6'(MAXL)) begin
      errors++;
      $display("FAIL win_hold win %b level %0d want 1 %0d", win, level, MAXL);
    end
  endtask

  task automatic test_fail;
    int bad;
    do_start(1'b0);
    checks++;
    if (win !== 1'b0 || level !== 6'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_win win %b level %0d busy %b want 0 0 1", win, level, busy);
    end
    play_level(bad);
    enter(led_of(exp_seq[0]));
    play_level(bad);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fail_lvl2_playback bad_cycles %0d want 0", bad);
    end
    enter(4'b0011);
    checks++;
    if (game_over !== 1'b1 || level !== 6'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_hot_entry go %b level %0d busy %b want 1 2 0", game_over, level, busy);
    end
    do_start(1'b0);
    play_level(bad);
    enter(led_of(exp_seq[0]));
    play_level(bad);
    enter(led_of(exp_seq[0] ^ 2'd1));
    checks++;
    if (game_over !== 1'b1 || level !== 6'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrong_onehot go %b level %0d busy %b want 1 2 0", game_over, level, busy);
    end
    do_start(1'b0);
    gen_tick();
    checks++;
    if (game_over !== 1'b0 || level !== 6'd1) begin
      errors++;
      $display("FAIL restart_from_fail go %b level %0d want 0 1", game_over, level);
    end
  endtask

  // Entered in the first SHOW_ON cycle of a level-1 playback
  task automatic test_ignore;
    int bad;
    to_cmp     = 4'd0;
    input_done = 1'b1;
    start      = 1'b1;
    playback(bad);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ignore_playback bad_cycles %0d want 0", bad);
    end
    tick();
    input_done = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || game_over !== 1'b0 || level !== 6'd1) begin
      errors++;
      $display("FAIL held_done_no_edge busy %b go %b level %0d want 1 0 1", busy, game_over, level);
    end
    enter(led_of(exp_seq[0]));
    gen_tick();
    checks++;
    if (level !== 6'd2 || led_show !== led_of(exp_seq[0])) begin
      errors++;
      $display("FAIL after_ignore level %0d led %b want 2 %b", level, led_show, led_of(exp_seq[0]));
    end
    tick();
    tick();
  endtask

  // Entered in the third SHOW_ON cycle of a level-2 playback
  task automatic test_onoff;
    on_off = 1'b0;
    checks++;
    if (led_show !== led_of(exp_seq[0]) || busy !== 1'b1) begin
      errors++;
      $display("FAIL onoff_not_yet led %b busy %b want %b 1", led_show, busy, led_of(exp_seq[0]));
    end
    tick();
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL onoff_idle got %h want 0", outs);
    end
    start = 1'b1;
    idle_tick();
    start = 1'b0;
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL onoff_start_blocked got %h want 0", outs);
    end
    on_off = 1'b1;
    idle_tick();
  endtask

  task automatic test_reset_mid;
    int bad;
    repeat (3) idle_tick();
    do_start(1'b1);
    play_level(bad);
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL async_reset_outputs got %h want 0", outs);
    end
    checks++;
    if (dut.u_lfsr.lfsr !== 8'h01) begin
      errors++;
      $display("FAIL async_reset_lfsr got %h want 01", dut.u_lfsr.lfsr);
    end
    exp_lfsr = 8'h01;
    tick();
    tick();
    reset = 1'b1;
    do_start(1'b1);
    gen_tick();
    playback(bad);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL post_reset_playback bad_cycles %0d want 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_lfsr = 8'h01;
    exp_len  = 0;
    test_reset();
    test_first_round();
    test_win();
    test_fail();
    test_ignore();
    test_onoff();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
